// File: rtl/ofm_stream_reader_pkg.sv
// Shared constants, FSM encoding and tag helper for the OFM stream reader.
package ofm_stream_reader_pkg;
  localparam int ELEMS  = 16;
  localparam int KEEP_W = 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  // Only the final word may be partial; a zero remainder means it is full.
  function automatic logic [KEEP_W-1:0] keep_of(input logic last, input logic [3:0] rem);
    return (last && rem != 4'd0) ? {1'b0, rem} : KEEP_W'(ELEMS);
  endfunction
endpackage

// File: rtl/ofm_stream_reader_if.sv
// Valid/ready word stream carrying OFM results with keep count and last flag.
interface ofm_stream_reader_if #(parameter int INOUT_WIDTH = 256);
  import ofm_stream_reader_pkg::*;
  logic                   valid;
  logic                   ready;
  logic [INOUT_WIDTH-1:0] data;
  logic [KEEP_W-1:0]      keep;
  logic                   last;

  modport master(output valid, data, keep, last, input ready);
  modport slave (input valid, data, keep, last, output ready);
endinterface

// File: rtl/ofm_stream_fifo.sv
// Small synchronous FIFO; pointer + count, head word shown combinationally.
module ofm_stream_fifo #(
  parameter int W     = 262,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;

  // Push while full is only legal together with a pop; the slot written is
  // the one being read out this same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/ofm_stream_reader.sv
// Drains num_elem results from the OFM DPRAM read port as a stream of 16-element words.
module ofm_stream_reader
  import ofm_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int INOUT_WIDTH  = 256,
  parameter int OFM_RAM_SIZE = 692224,
  parameter int BUF_DEPTH    = 4,
  localparam int AW          = $clog2(OFM_RAM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW-1:0]          base_addr,
  input  logic [AW-1:0]          num_elem,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_re,
  output logic [AW-1:0]          ram_addr,
  input  logic [INOUT_WIDTH-1:0] ram_dout,
  ofm_stream_reader_if.master    m
);
  localparam int SH = $clog2(INOUT_WIDTH / DATA_WIDTH);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int FW = 1 + KEEP_W + INOUT_WIDTH;

  state_t        state;
  logic [AW-1:0] addr, words, k;
  logic [3:0]    rem;
  logic          inflight, inflight_last;
  logic [CW-1:0] buf_count;
  logic          buf_empty, issue, last_issue, pop;
  logic [FW-1:0] head;

  // Credit: buffered words plus the read in flight must leave room.
  assign issue      = (state == RUN) && ((int'(buf_count) + int'(inflight)) < BUF_DEPTH);
  assign last_issue = (k == words - 1'b1);
  assign pop        = m.valid && m.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      words         <= '0;
      k             <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && last_issue;
      case (state)
        IDLE: if (start) begin
          addr  <= base_addr;
          words <= AW'(({1'b0, num_elem} + (AW+1)'(ELEMS - 1)) >> SH);
          rem   <= num_elem[3:0];
          k     <= '0;
          state <= (num_elem == '0) ? FIN : RUN;
        end
        RUN: if (issue) begin
          addr <= addr + AW'(ELEMS);
          k    <= k + 1'b1;
          if (last_issue) state <= DRAIN;
        end
        // Leave as the final word pops so done lands right after its handshake.
        DRAIN: if (!inflight && (buf_count == '0 || (buf_count == CW'(1) && pop)))
          state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == FIN);
  assign ram_re   = issue;
  assign ram_addr = addr;

  ofm_stream_fifo #(.W(FW), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({inflight_last, keep_of(inflight_last, rem), ram_dout}),
    .pop   (pop),
    .dout  (head),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign m.valid = !buf_empty;
  assign {m.last, m.keep, m.data} = head;
endmodule

// File: tb/tb_ofm_stream_reader.sv
// Directed bench for ofm_stream_reader: vector table plus stall, zero-length and reset sequences.
module tb_ofm_stream_reader;
  import ofm_stream_reader_pkg::*;
  localparam int AW = 20;
  localparam int W  = 256;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, ram_re;
  logic [AW-1:0] base_addr, num_elem, ram_addr;
  logic [W-1:0]  ram_dout;
  logic          rdy = 1'b0;

  ofm_stream_reader_if #(.INOUT_WIDTH(W)) s_if ();
  assign s_if.ready = rdy;

  ofm_stream_reader #(.DATA_WIDTH(16), .INOUT_WIDTH(W), .OFM_RAM_SIZE(692224), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_elem(num_elem),
    .busy(busy), .done(done), .ram_re(ram_re), .ram_addr(ram_addr), .ram_dout(ram_dout), .m(s_if));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] word_of(input logic [AW-1:0] a);
    logic [W-1:0] w;
    for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(a + AW'(i)) ^ 16'hA5A5;
    return w;
  endfunction

  always @(posedge clk) begin
    if (ram_re) ram_dout <= word_of(ram_addr);
    else        ram_dout <= {8{32'hDEADBEEF}};
  end

  int rmode = 0;  // 0 always ready, 1 random, 2 stalled
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       rdy = 1'b1;
      1:       rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
  end

  int cyc = 0, reads = 0, dones = 0, outst = 0;
  int start_cyc = 0, first_v_cyc = -1, last_hs_cyc = 0, done_cyc = 0;
  logic [AW-1:0] addr_q[$];
  logic [W-1:0]  data_q[$];
  logic [4:0]    keep_q[$];
  logic          last_q[$];
  logic          prev_stall = 1'b0;
  logic [W+5:0]  prev_word;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin start_cyc = cyc; first_v_cyc = -1; end
      if (s_if.valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (prev_stall && (!s_if.valid || {s_if.last, s_if.keep, s_if.data} != prev_word)) begin
        errors++;
        $display("FAIL hold_stable: word changed under backpressure at cycle %0d", cyc);
      end
      prev_stall = s_if.valid && !s_if.ready;
      prev_word  = {s_if.last, s_if.keep, s_if.data};
      if (ram_re) begin reads++; outst++; addr_q.push_back(ram_addr); end
      if (s_if.valid && s_if.ready) begin
        outst--;
        data_q.push_back(s_if.data);
        keep_q.push_back(s_if.keep);
        last_q.push_back(s_if.last);
        last_hs_cyc = cyc;
      end
      if (done) begin dones++; done_cyc = cyc; end
      if (outst > BD || outst < 0) begin
        errors++;
        $display("FAIL occupancy: outstanding %0d outside 0..%0d at cycle %0d", outst, BD, cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    addr_q.delete(); data_q.delete(); keep_q.delete(); last_q.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(posedge clk); #1;
    base_addr = b; num_elem = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = dones;
    n  = 0;
    while (dones == d0 && n < 3000) begin @(posedge clk); n++; end
    chk({name, " done_seen"}, 64'(n < 3000), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string name, input logic [AW-1:0] b, input int ew, input int lk);
    logic [AW-1:0] a;
    chk({name, " words"}, 64'(data_q.size()), 64'(ew));
    chk({name, " reads"}, 64'(addr_q.size()), 64'(ew));
    for (int k = 0; k < ew && k < data_q.size() && k < addr_q.size(); k++) begin
      a = b + AW'(16 * k);
      chk($sformatf("%s addr[%0d]", name, k), 64'(addr_q[k]), 64'(a));
      chk_data($sformatf("%s data[%0d]", name, k), data_q[k], word_of(a));
      chk($sformatf("%s keep[%0d]", name, k), 64'(keep_q[k]), (k == ew - 1) ? 64'(lk) : 64'd16);
      chk($sformatf("%s last[%0d]", name, k), 64'(last_q[k]), 64'(k == ew - 1));
    end
    chk({name, " done_latency"}, 64'(done_cyc - last_hs_cyc), 64'd1);
    chk({name, " idle_after"}, 64'({busy, s_if.valid}), 64'd0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] num;
    int            rmode;
    int            exp_words;
    int            exp_keep;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int d0;
    int r0;
    vecs[0] = '{20'd0,       20'd32,   0, 2,  16};
    vecs[1] = '{20'd100,     20'd20,   0, 2,  4};
    vecs[2] = '{20'd0,       20'd256,  0, 16, 16};
    vecs[3] = '{20'd500,     20'd1000, 1, 63, 8};
    vecs[4] = '{20'hFFFF0,   20'd40,   0, 3,  8};
    vecs[5] = '{20'd7,       20'd1,    1, 1,  1};

    rst = 1'b1; start = 1'b0; base_addr = '0; num_elem = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",  64'(busy), 64'd0);
    chk("reset done",  64'(done), 64'd0);
    chk("reset ram_re", 64'(ram_re), 64'd0);
    chk("reset ram_addr", 64'(ram_addr), 64'd0);
    chk("reset valid", 64'(s_if.valid), 64'd0);
    chk("reset keep_last", 64'({s_if.keep, s_if.last}), 64'd0);
    chk_data("reset data", s_if.data, '0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      rmode = vecs[v].rmode;
      clr();
      d0 = dones;
      do_start(vecs[v].base, vecs[v].num);
      wait_done($sformatf("vec%0d", v));
      verify($sformatf("vec%0d", v), vecs[v].base, vecs[v].exp_words, vecs[v].exp_keep);
      chk($sformatf("vec%0d done_count", v), 64'(dones - d0), 64'd1);
      if (v == 0) chk("vec0 first_valid", 64'(first_v_cyc - start_cyc), 64'd3);
    end

    // zero-length transfer: no reads, done in the cycle after start
    rmode = 0; clr(); r0 = reads; d0 = dones;
    @(posedge clk); #1;
    base_addr = 20'd5; num_elem = '0; start = 1'b1;
    @(negedge clk);
    chk("zero busy_in_start_cycle", 64'(busy), 64'd0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zero busy", 64'(busy), 64'd1);
    chk("zero done", 64'(done), 64'd1);
    @(negedge clk);
    chk("zero busy_after", 64'(busy), 64'd0);
    chk("zero done_after", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero reads", 64'(reads - r0), 64'd0);
    chk("zero done_count", 64'(dones - d0), 64'd1);
    chk("zero words", 64'(data_q.size()), 64'd0);

    // backpressure: buffer fills, reads stop, head held
    rmode = 2; clr(); r0 = reads;
    do_start(20'd0, 20'd256);
    repeat (10) @(negedge clk);
    chk("stall reads", 64'(reads - r0), 64'd4);
    chk("stall ram_re", 64'(ram_re), 64'd0);
    chk("stall valid", 64'(s_if.valid), 64'd1);
    chk_data("stall head", s_if.data, word_of(20'd0));
    chk("stall keep", 64'(s_if.keep), 64'd16);
    chk("stall busy", 64'(busy), 64'd1);
    rmode = 0;
    wait_done("stall");
    verify("stall", 20'd0, 16, 16);

    // async reset mid-transfer
    rmode = 1; d0 = dones;
    do_start(20'd0, 20'd1000);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort ram_re", 64'(ram_re), 64'd0);
    chk("abort ram_addr", 64'(ram_addr), 64'd0);
    chk("abort valid", 64'(s_if.valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("abort no_done", 64'(dones - d0), 64'd0);

    // fresh transfer after abort, with a start pulse while busy that must be ignored
    rmode = 0; clr(); d0 = dones;
    do_start(20'd64, 20'd48);
    @(posedge clk); #1;
    base_addr = 20'd999; num_elem = 20'd16; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_start");
    r0 = reads;
    repeat (10) @(posedge clk);
    verify("busy_start", 20'd64, 3, 16);
    chk("busy_start done_count", 64'(dones - d0), 64'd1);
    chk("busy_start no_extra_reads", 64'(reads - r0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
